// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: access-size codes,
// the wait-state FSM encoding and the byte-lane mask helper.
package mem_stage_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Byte-lane write mask for a 32-bit word; size 2'b11 behaves as a word.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] mask;
    case (size)
      SZ_BYTE: mask = 4'b0001 << lane;
      SZ_HALF: mask = lane[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mem_stage_dmem.sv
// Data memory for the MEM stage: DEPTH x DATA_W words, per-byte write
// enables, synchronous write and combinational (asynchronous) read.
module mem_stage_dmem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Update only the enabled byte lanes of the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data memory access with byte/half/word sizing,
// sign/zero extension, optional multi-cycle latency with an upstream stall,
// branch resolution toward IF and the MEM_WB pipeline register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int PC_W        = 8,
  parameter int REG_W       = 5,
  parameter int MEM_LATENCY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EX_MEM_MemRead,
  input  logic              EX_MEM_MemWrite,
  input  logic              EX_MEM_MemtoReg,
  input  logic              EX_MEM_RegWrite,
  input  logic              EX_MEM_Branch,
  input  logic              EX_MEM_Zero,
  input  logic [1:0]        EX_MEM_Size,
  input  logic              EX_MEM_Unsigned,
  input  logic [DATA_W-1:0] EX_MEM_ALUResult,
  input  logic [DATA_W-1:0] EX_MEM_WriteData,
  input  logic [REG_W-1:0]  EX_MEM_WriteReg,
  input  logic [PC_W-1:0]   EX_MEM_BranchTarget,
  output logic              BranchTaken,
  output logic [PC_W-1:0]   BranchTarget,
  output logic              MemStall,
  output logic              MEM_WB_RegWrite,
  output logic              MEM_WB_MemtoReg,
  output logic [DATA_W-1:0] MEM_WB_ReadData,
  output logic [DATA_W-1:0] MEM_WB_ALUResult,
  output logic [REG_W-1:0]  MEM_WB_WriteReg,
  output logic              MEM_WB_Misaligned
);

  localparam int NB = DATA_W / 8;
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_t            state;
  logic [CW-1:0]     wait_cnt;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] word_idx;
  logic              mem_op;
  logic              misaligned;
  logic              mem_req;
  logic              mem_we;
  logic [NB-1:0]     byte_en;
  logic [DATA_W-1:0] store_data;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] load_data;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  assign lane       = EX_MEM_ALUResult[1:0];
  assign word_idx   = EX_MEM_ALUResult[ADDR_W+1:2];
  assign mem_op     = EX_MEM_MemRead | EX_MEM_MemWrite;
  assign misaligned = mem_op & (((EX_MEM_Size == SZ_HALF) & lane[0]) |
                                (EX_MEM_Size[1] & (lane != 2'b00)));
  assign mem_req    = mem_op & ~misaligned;
  assign mem_we     = EX_MEM_MemWrite & ~misaligned & ~MemStall & rst;
  assign byte_en    = NB'(lane_mask(EX_MEM_Size, lane));

  assign BranchTaken  = EX_MEM_Branch & EX_MEM_Zero & ~MemStall;
  assign BranchTarget = EX_MEM_BranchTarget;

  mem_stage_dmem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_dmem (
    .clk   (clk),
    .we    (mem_we),
    .be    (byte_en),
    .addr  (word_idx),
    .wdata (store_data),
    .rdata (rdata)
  );

  // Hold upstream while an aligned access is still waiting on memory.
  always_comb begin
    MemStall = 1'b0;
    if (MEM_LATENCY != 0) begin
      if (state == IDLE) MemStall = mem_req & rst;
      else               MemStall = (wait_cnt != '0);
    end
  end

  // Replicate store data so every lane the mask can select carries it.
  always_comb begin
    store_data = EX_MEM_WriteData;
    case (EX_MEM_Size)
      SZ_BYTE: store_data = {NB{EX_MEM_WriteData[7:0]}};
      SZ_HALF: store_data = {(NB/2){EX_MEM_WriteData[15:0]}};
      default: store_data = EX_MEM_WriteData;
    endcase
  end

  // Pick the addressed lane(s) out of the word and extend to full width.
  always_comb begin
    byte_sel  = rdata[{lane, 3'b000} +: 8];
    half_sel  = rdata[{lane[1], 4'b0000} +: 16];
    load_data = rdata;
    case (EX_MEM_Size)
      SZ_BYTE: load_data = {{(DATA_W-8){~EX_MEM_Unsigned & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{(DATA_W-16){~EX_MEM_Unsigned & half_sel[15]}}, half_sel};
      default: load_data = rdata;
    endcase
  end

  // Wait-state sequencer: count down the extra latency of each access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else if (MEM_LATENCY != 0) begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            state    <= WAIT;
            wait_cnt <= CW'(MEM_LATENCY - 1);
          end
        end
        WAIT: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
          else                state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // MEM_WB register: bubble while stalled, otherwise capture the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MEM_WB_RegWrite   <= 1'b0;
      MEM_WB_MemtoReg   <= 1'b0;
      MEM_WB_ReadData   <= '0;
      MEM_WB_ALUResult  <= '0;
      MEM_WB_WriteReg   <= '0;
      MEM_WB_Misaligned <= 1'b0;
    end else if (MemStall) begin
      MEM_WB_RegWrite   <= 1'b0;
      MEM_WB_MemtoReg   <= 1'b0;
      MEM_WB_ReadData   <= '0;
      MEM_WB_ALUResult  <= '0;
      MEM_WB_WriteReg   <= '0;
      MEM_WB_Misaligned <= 1'b0;
    end else begin
      MEM_WB_RegWrite   <= EX_MEM_RegWrite & ~misaligned;
      MEM_WB_MemtoReg   <= EX_MEM_MemtoReg;
      MEM_WB_ReadData   <= (EX_MEM_MemRead & ~EX_MEM_MemWrite & ~misaligned) ? load_data : '0;
      MEM_WB_ALUResult  <= EX_MEM_ALUResult;
      MEM_WB_WriteReg   <= EX_MEM_WriteReg;
      MEM_WB_Misaligned <= misaligned;
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Parametrised MEM pipeline stage between EX_STAGE and write-back. Holds the data memory and performs byte/half/word loads and stores with sign or zero extension. Supports a configurable multi-cycle memory latency with a stall handshake to upstream stages. Resolves branches toward IF_STAGE and registers the MEM_WB pipeline outputs.

Parameters:
DATA_W, 32, datapath and memory word width (bits)
ADDR_W, 8, memory word-index width; DEPTH = 2**ADDR_W words
PC_W, 8, program counter / branch target width
REG_W, 5, register-file index width
MEM_LATENCY, 0, extra wait cycles per load/store (0 = single-cycle access)

Ports:
clk  in  1  stage clock, rising edge
rst  in  1  asynchronous active-low reset
EX_MEM_MemRead  in  1  load request
EX_MEM_MemWrite  in  1  store request
EX_MEM_MemtoReg  in  1  write-back selects memory data
EX_MEM_RegWrite  in  1  destination register write enable
EX_MEM_Branch  in  1  branch instruction
EX_MEM_Zero  in  1  ALU zero flag
EX_MEM_Size  in  2  00 byte, 01 half, 10 word, 11 treated as word
EX_MEM_Unsigned  in  1  zero-extend loads when 1
EX_MEM_ALUResult  in  DATA_W  byte address / ALU result
EX_MEM_WriteData  in  DATA_W  store data
EX_MEM_WriteReg  in  REG_W  destination register
EX_MEM_BranchTarget  in  PC_W  branch destination
BranchTaken  out  1  to IF_STAGE
BranchTarget  out  PC_W  to IF_STAGE
MemStall  out  1  freeze PC, IF_ID, ID_EX, EX_MEM
MEM_WB_RegWrite  out  1  registered
MEM_WB_MemtoReg  out  1  registered
MEM_WB_ReadData  out  DATA_W  registered, extended load data
MEM_WB_ALUResult  out  DATA_W  registered
MEM_WB_WriteReg  out  REG_W  registered
MEM_WB_Misaligned  out  1  registered one-cycle exception flag

Behaviour:
- Reset (rst=0, async): all MEM_WB_* = 0, MemStall = 0, FSM = IDLE, wait counter = 0. Memory contents are not reset. Reset mid-access aborts it; an uncommitted store never writes.
- Addressing: word index = ALUResult[ADDR_W+1:2] (wraps modulo DEPTH); lane = ALUResult[1:0]; upper address bits ignored.
- Misaligned: half with lane[0]=1, or word with lane!=00. No memory write, no stall, MEM_WB_RegWrite=0, MEM_WB_Misaligned=1 for that cycle.
- Read+Write both set: store wins; MEM_WB_ReadData=0.
- Stores: byte writes WriteData[7:0] to the lane, half writes [15:0] to lanes 1:0 or 3:2, word writes all lanes. Other lanes are unchanged. The write commits on the final access cycle.
- Loads: select lane bytes, then sign-extend (Unsigned=0) or zero-extend (Unsigned=1). Memory is read combinationally (async read). The result is captured into MEM_WB on the final access cycle.
- MEM_LATENCY=0: no FSM activity. MemStall is always 0. Every access completes in one cycle; MEM_WB updates on the next edge.
- MEM_LATENCY=N>0, FSM IDLE/WAIT:
  - IDLE with an aligned load/store: MemStall=1 combinationally, counter loads N-1, go to WAIT.
  - WAIT: MemStall=1 while counter!=0, decrement each cycle.
  - WAIT with counter==0: MemStall=0, commit store / capture load, return to IDLE.
  - Total access = N+1 cycles. Upstream holds EX_MEM_* stable while MemStall=1.
  - Every stall cycle writes a bubble into MEM_WB (RegWrite=0, Misaligned=0).
  - Back-to-back accesses re-enter WAIT with no idle cycle.
- Non-memory instructions: pass ALUResult, WriteReg, RegWrite, MemtoReg to MEM_WB in one cycle.
- Branch: BranchTaken = Branch & Zero & ~MemStall, combinational; BranchTarget = EX_MEM_BranchTarget, passed through.

Decomposition:
- Package mem_stage_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state enum (IDLE, WAIT), lane-mask helper function.
- One sub-module, mem_stage_dmem: DEPTH x DATA_W RAM with per-byte write enables and async read.
- Alignment, extension and FSM logic stay in mem_stage.

Test Plan:
1. MEM_LATENCY=0: SW 0xDEADBEEF to addr 0x10, then LW addr 0x10 -> next cycle MEM_WB_ReadData=0xDEADBEEF, MemtoReg=1, MemStall never 1.
2. After test 1, LB addr 0x13 -> 0xFFFFFFDE; LBU addr 0x13 -> 0x000000DE; LH addr 0x10 -> 0xFFFFBEEF; SB 0x55 to 0x11, then LW 0x10 -> 0xDEAD55EF.
3. LW addr 0x12 -> MEM_WB_Misaligned=1, MEM_WB_RegWrite=0, memory unchanged, no stall.
4. MEM_LATENCY=3: LW -> MemStall high exactly 3 cycles, three bubble cycles (RegWrite=0), then data valid; a back-to-back SW stalls 3 more cycles.
5. MEM_LATENCY=3: reset asserted during the 2nd stall cycle of SW 0x12345678 to addr 0x20 -> outputs 0 at once, MemStall=0, later LW 0x20 returns the prior value.
6. Branch=1, Zero=1, BranchTarget=16 -> BranchTaken=1, BranchTarget=16 in the same cycle; Zero=0 -> BranchTaken=0.
